// File: rtl/oven_pkg.sv
// Shared types and constants for the oven countdown timer.
// Optional build macro used by the design: OVEN_PAUSE_EN (enables the PAUSE state).
package oven_pkg;

   // Controller states; PAUSE is only reachable when OVEN_PAUSE_EN is defined
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Default width of time values in seconds
   localparam int TIME_W_DEF = 10;

   // Width of one BCD digit
   localparam int BCD_W = 4;

endpackage

// File: rtl/btn_press_sync.sv
// Raw active-low push button to single-cycle press pulse.
// Two-flop synchronizer followed by a registered falling-edge detector.
module btn_press_sync (
   input  logic clock,
   input  logic reset,
   input  logic i_btn_n,
   output logic o_press
);

   logic r_sync1;
   logic r_sync2;
   logic r_sync_d;
   logic r_press;

   // Synchronize the raw button and emit one pulse per high-to-low transition
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_sync_d <= 1'b1;
         r_press  <= 1'b0;
      end else begin
         r_sync1  <= i_btn_n;
         r_sync2  <= r_sync1;
         r_sync_d <= r_sync2;
         r_press  <= r_sync_d & ~r_sync2;
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/oven_countdown.sv
// Oven countdown timer: loads a cook time, counts it down once per second while
// heating, then sounds an alarm for ALARM_S seconds.
// Build macro OVEN_PAUSE_EN: when defined, stop during RUN pauses instead of aborting.
module oven_countdown
   import oven_pkg::*;
#(
   parameter int CLK_HZ  = 50000000,
   parameter int TIME_W  = TIME_W_DEF,
   parameter int ALARM_S = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [TIME_W-1:0] input_time,
   input  logic              btnstart,
   input  logic              btnstop,
   output logic [TIME_W-1:0] remaining_time,
   output logic [BCD_W-1:0]  min_tens,
   output logic [BCD_W-1:0]  min_units,
   output logic [BCD_W-1:0]  sec_tens,
   output logic [BCD_W-1:0]  sec_units,
   output logic              heater_on,
   output logic              done,
   output logic              alarm
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int AW = (ALARM_S > 1) ? $clog2(ALARM_S) : 1;

   logic              w_start_p;
   logic              w_stop_p;
   logic              w_tick;

   state_t            r_state;
   logic [PW-1:0]     r_presc;
   logic [AW-1:0]     r_alarm_cnt;
   logic [TIME_W-1:0] r_remaining;
   logic              r_heater;
   logic              r_done;
   logic              r_alarm;

   logic [31:0]       w_val;
   logic [31:0]       w_min;
   logic [31:0]       w_sec;

   btn_press_sync u_start (
      .clock   (clock),
      .reset   (reset),
      .i_btn_n (btnstart),
      .o_press (w_start_p)
   );

   btn_press_sync u_stop (
      .clock   (clock),
      .reset   (reset),
      .i_btn_n (btnstop),
      .o_press (w_stop_p)
   );

   // One-second tick: the cycle on which the prescaler wraps
   assign w_tick = (r_presc == PW'(CLK_HZ - 1));

   // Controller state, prescaler, countdown value and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_presc     <= '0;
         r_alarm_cnt <= '0;
         r_remaining <= '0;
         r_heater    <= 1'b0;
         r_done      <= 1'b0;
         r_alarm     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // Track the time-setting block continuously while idle
               r_remaining <= input_time;
               r_presc     <= '0;
               r_alarm_cnt <= '0;
               if (w_start_p && !w_stop_p && (input_time != '0)) begin
                  r_state  <= S_RUN;
                  r_heater <= 1'b1;
               end
            end

            S_RUN: begin
               if (w_stop_p) begin
                  // Stop wins over a simultaneous start
                  r_heater <= 1'b0;
`ifdef OVEN_PAUSE_EN
                  r_state  <= S_PAUSE;
`else
                  r_state  <= S_IDLE;
                  r_presc  <= '0;
`endif
               end else if (w_tick) begin
                  r_presc <= '0;
                  if (r_remaining <= TIME_W'(1)) begin
                     r_remaining <= '0;
                     r_state     <= S_DONE;
                     r_done      <= 1'b1;
                     r_alarm     <= 1'b1;
                     r_heater    <= 1'b0;
                     r_alarm_cnt <= '0;
                  end else begin
                     r_remaining <= r_remaining - TIME_W'(1);
                  end
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end

`ifdef OVEN_PAUSE_EN
            S_PAUSE: begin
               // Prescaler and remaining time stay frozen here
               if (w_stop_p) begin
                  r_state <= S_IDLE;
                  r_presc <= '0;
               end else if (w_start_p) begin
                  r_state  <= S_RUN;
                  r_heater <= 1'b1;
               end
            end
`endif

            S_DONE: begin
               if (w_start_p || w_stop_p) begin
                  r_state <= S_IDLE;
                  r_alarm <= 1'b0;
                  r_presc <= '0;
               end else if (w_tick) begin
                  r_presc <= '0;
                  if (r_alarm_cnt == AW'(ALARM_S - 1)) begin
                     r_state <= S_IDLE;
                     r_alarm <= 1'b0;
                  end else begin
                     r_alarm_cnt <= r_alarm_cnt + AW'(1);
                  end
               end else begin
                  r_presc <= r_presc + PW'(1);
               end
            end

            default: begin
               r_state  <= S_IDLE;
               r_presc  <= '0;
               r_heater <= 1'b0;
               r_alarm  <= 1'b0;
            end
         endcase
      end
   end

   // MM:SS BCD view of the remaining time; minute tens clamp at 9
   always_comb begin
      w_val     = 32'(r_remaining);
      w_min     = w_val / 32'd60;
      w_sec     = w_val % 32'd60;
      min_tens  = ((w_min / 32'd10) > 32'd9) ? BCD_W'(9) : BCD_W'(w_min / 32'd10);
      min_units = BCD_W'(w_min % 32'd10);
      sec_tens  = BCD_W'(w_sec / 32'd10);
      sec_units = BCD_W'(w_sec % 32'd10);
   end

   assign remaining_time = r_remaining;
   assign heater_on      = r_heater;
   assign done           = r_done;
   assign alarm          = r_alarm;

endmodule
